craft_round_controller: RTL
===========================

# craft_round_controller

Sequencing FSM for the nibble-serial CRAFT encryption datapath. It drives the select, enable and round-index controls of `craft_state_register`, `craft_mix_columns`, `craft_key_register` and `craft_sbox`. One 64-bit block passes through 32 rounds in a fixed 642-cycle schedule, under a start/done handshake that faces the system.

## Interface
- `ROUNDS`, 32: rounds per block; legal range 1–32.
- `NIBBLES`, 16: serial nibble cycles per round; fixed for CRAFT and kept only for readability.
- `clk`  in  1  system clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to encrypt; sampled only in IDLE or DONE.
- `busy`  out  1  high in LOAD, MC and SUB.
- `done`  out  1  one-cycle pulse in the DONE state.
- `round`  out  8  current round index, routed to `craft_key_register.r`.
- `nib`  out  4  nibble index within the SUB phase.
- `ce`  out  1  state-register clock enable.
- `CS1`, `CS0`  out  1 each  state-register mode select.
- `CM1`, `CM0`  out  1 each  mix-columns controls.
- `key_en`  out  1  key-register enable.
- `CK0`  out  1  key-register mode: 0 = load key/tweak, 1 = serial step.
- `sbox_bypass`  out  1  routes the nibble around the S-box.

## Operation
- States: IDLE → LOAD → MC → SUB → (MC of the next round, or DONE) → IDLE.
- IDLE
  - All outputs are 0.
  - `start`=1 moves to LOAD.
- LOAD, 1 cycle
  - `ce`=1, {CS1,CS0}=00 (parallel plaintext load).
  - `key_en`=1, `CK0`=0.
  - `round` is cleared to 0. Next state is MC.
- MC, 4 cycles with k=0..3 from an internal 2-bit counter
  - `ce`=1, {CS1,CS0}=10 (column rotate through mix columns).
  - `CM1`=1; `CM0`=1 only when k=0.
  - `key_en`=0.
  - After k=3, next state is SUB.
- SUB, 16 cycles with `nib`=0..15
  - `ce`=1, `key_en`=1, `CK0`=1.
  - {CS1,CS0}=01 (serial add-key and S-box shift).
  - When `nib`=15 in a non-final round, {CS1,CS0}=11 (shift plus PN permutation).
  - In the final round (`round`=ROUNDS-1), `sbox_bypass`=1 for all 16 cycles and no permutation is applied: {CS1,CS0} stays 01 at `nib`=15.
  - Leaving `nib`=15: if `round`<ROUNDS-1, `round` increments and the FSM enters MC. Otherwise it enters DONE and `round` holds.
- DONE, 1 cycle
  - `done`=1, `busy`=0, all datapath controls are 0.
  - `start`=1 in this cycle goes directly to LOAD (back-to-back blocks). Otherwise the FSM returns to IDLE.
- `start` in LOAD, MC or SUB is ignored and not queued.
- Counters:
  - `nib` wraps 15→0 and is 0 outside SUB.
  - The MC counter wraps 3→0.
  - `round` never exceeds ROUNDS-1.

## Timing
- Reset
  - `rst`=1 forces IDLE on the next edge and clears all counters.
  - All outputs are 0, including in the cycle after reset, and regardless of state, so reset mid-block abandons the block.
  - `rst` has priority over `start` and the abort input.
- Cycle numbering: cycle 0 is the first cycle after the edge that samples `start`=1.
- Cycle 0 is LOAD.
- Round r occupies cycles 1+20r … 20+20r:
  - MC: 1+20r … 4+20r.
  - SUB: 5+20r … 20+20r.
- With ROUNDS=32, DONE is cycle 641. Latency from the `start` edge to `done` is 642 cycles.
- Back-to-back: `start` high during DONE puts LOAD at cycle 642, so throughput is one block per 642 cycles.
- All outputs are registered Moore outputs; there is no combinational path from `start` to any output.

## Configuration
- `CRAFT_CTRL_ABORT_EN`
  - Defined: adds input `abort` (1 bit). `abort`=1 in LOAD, MC or SUB returns the FSM to IDLE on the next edge with all outputs 0. No `done` pulse is issued and `round` clears. `abort` is ignored in IDLE and DONE.
  - Undefined: the port does not exist and every started block runs to DONE.

## Test plan
- Reset and idle: hold `rst` 3 cycles, then leave `start`=0 for 10 cycles → all outputs stay 0 and `busy`=0 throughout.
- Single block: pulse `start` → LOAD at cycle 0 with {CS1,CS0}=00 and `CK0`=0.
  - Cycle 1: `CM0`=1, `CM1`=1.
  - Cycle 20: {CS1,CS0}=11, `nib`=15.
  - Cycle 21: `round`=1.
  - Cycles 625–640: `sbox_bypass`=1 and no {CS1,CS0}=11.
  - `done`=1 only at cycle 641.
- Back-to-back: `start` high at cycle 641 → LOAD at cycle 642 and second `done` at cycle 1283.
- Ignored start: toggle `start` every cycle during cycles 1–640 → schedule unchanged, exactly one `done`.
- Mid-block reset: assert `rst` at cycle 300 → IDLE next cycle with all outputs 0. A new `start` then gives `done` 642 cycles later.
- Abort (`CRAFT_CTRL_ABORT_EN` defined): `abort` at cycle 100 → IDLE at cycle 101, `round`=0, no `done`. With the macro undefined, the build contains no `abort` port.

Source files
------------

// File: rtl/craft_round_controller.sv
// Round/phase sequencer for the nibble-serial CRAFT datapath: LOAD, then ROUNDS x (4 MC + 16 SUB), then DONE.
// Optional `abort` input is compiled in when CRAFT_CTRL_ABORT_EN is defined.
module craft_round_controller #(
  parameter int ROUNDS  = 32,
  parameter int NIBBLES = 16
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CRAFT_CTRL_ABORT_EN
  input  logic       abort,
`endif
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] round,
  output logic [3:0] nib,
  output logic       ce,
  output logic       CS1,
  output logic       CS0,
  output logic       CM1,
  output logic       CM0,
  output logic       key_en,
  output logic       CK0,
  output logic       sbox_bypass
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MC   = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [3:0] LAST_NIB   = 4'(NIBBLES - 1);

  state_t     r_state;
  logic [1:0] r_k;

  state_t     w_state_n;
  logic [1:0] w_k_n;
  logic [3:0] w_nib_n;
  logic [7:0] w_round_n;
  logic       w_abort;
  logic       w_last_n;

`ifdef CRAFT_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_k_n     = '0;
    w_nib_n   = '0;
    w_round_n = round;
    case (r_state)
      IDLE: begin
        w_round_n = '0;
        if (start) w_state_n = LOAD;
      end
      LOAD: begin
        w_round_n = '0;
        w_state_n = MC;
      end
      MC: begin
        if (r_k == 2'd3) begin
          w_state_n = SUB;
        end else begin
          w_k_n = 2'(r_k + 2'd1);
        end
      end
      SUB: begin
        if (nib != LAST_NIB) begin
          w_nib_n = 4'(nib + 4'd1);
        end else if (round < LAST_ROUND) begin
          w_round_n = 8'(round + 8'd1);
          w_state_n = MC;
        end else begin
          w_state_n = DONE;
        end
      end
      DONE: begin
        w_round_n = '0;
        w_state_n = start ? LOAD : IDLE;
      end
      default: begin
        w_round_n = '0;
        w_state_n = IDLE;
      end
    endcase
    // Abort only acts while a block is in flight; IDLE and DONE keep their normal transitions.
    if (w_abort && (r_state == LOAD || r_state == MC || r_state == SUB)) begin
      w_state_n = IDLE;
      w_k_n     = '0;
      w_nib_n   = '0;
      w_round_n = '0;
    end
  end

  assign w_last_n = (w_round_n == LAST_ROUND);

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      nib         <= '0;
      round       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ce          <= 1'b0;
      CS1         <= 1'b0;
      CS0         <= 1'b0;
      CM1         <= 1'b0;
      CM0         <= 1'b0;
      key_en      <= 1'b0;
      CK0         <= 1'b0;
      sbox_bypass <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_k         <= w_k_n;
      nib         <= w_nib_n;
      round       <= w_round_n;
      busy        <= (w_state_n == LOAD) || (w_state_n == MC) || (w_state_n == SUB);
      done        <= (w_state_n == DONE);
      ce          <= (w_state_n == LOAD) || (w_state_n == MC) || (w_state_n == SUB);
      CS1         <= (w_state_n == MC) ||
                     ((w_state_n == SUB) && (w_nib_n == LAST_NIB) && !w_last_n);
      CS0         <= (w_state_n == SUB);
      CM1         <= (w_state_n == MC);
      CM0         <= (w_state_n == MC) && (w_k_n == 2'd0);
      key_en      <= (w_state_n == LOAD) || (w_state_n == SUB);
      CK0         <= (w_state_n == SUB);
      sbox_bypass <= (w_state_n == SUB) && w_last_n;
    end
  end

endmodule
